// File: rtl/prg_loader.sv
// Copies a downloaded .prg image (2-byte load-address header + payload) from the
// data_io buffer into main RAM over a request/ack DMA port, then patches the BASIC pointers.
module prg_loader #(
    parameter bit          PATCH_PTRS = 1'b1,
    parameter logic [15:0] PTR_BASE   = 16'h002A,
    parameter int          BUF_BYTES  = 16384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        downloading,
    input  logic [15:0] size,
    output logic [13:0] io_a,
    input  logic [7:0]  io_dout,
    output logic        dma_req,
    input  logic        dma_ack,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_REQ   = 3'd2,
        S_FETCH = 3'd3,
        S_COPY  = 3'd4,
        S_PATCH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [15:0] BUF_LEN = 16'(BUF_BYTES);

    state_t      state, state_n;
    logic        dl_s1, dl_s2, dl_d;
    logic [15:0] len;
    logic [15:0] idx;
    logic [15:0] load;
    logic [1:0]  hdr_cnt;
    logic [2:0]  patch_cnt;

    logic        trigger;
    logic        active;
    logic        abort;
    logic [15:0] size_len;
    logic [15:0] idx_inc;
    logic [15:0] copy_addr;
    logic [15:0] end_addr;
    logic        last_byte;
    logic        wrap;

    assign trigger   = dl_d & ~dl_s2;
    assign active    = (state == S_HDR) || (state == S_REQ) || (state == S_FETCH) ||
                       (state == S_COPY) || (state == S_PATCH);
    assign abort     = active & dl_s2;
    assign size_len  = (size > BUF_LEN) ? BUF_LEN : size;
    assign idx_inc   = idx + 16'd1;
    assign copy_addr = load + idx - 16'd2;
    assign end_addr  = load + len - 16'd2;
    assign last_byte = (idx_inc == len);
    // Writing the top of the address space with bytes still pending means the image overflows.
    assign wrap      = (copy_addr == 16'hFFFF) && !last_byte;
    assign dbg_state = state;

    always_comb begin
        state_n  = state;
        io_a     = 14'd0;
        ram_addr = 16'd0;
        ram_dout = 8'd0;
        ram_we   = 1'b0;
        dma_req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger)
                    state_n = (size_len <= 16'd2) ? S_DONE : S_HDR;
            end
            S_HDR: begin
                busy = 1'b1;
                io_a = {13'd0, hdr_cnt != 2'd0};
                if (hdr_cnt == 2'd2)
                    state_n = S_REQ;
            end
            S_REQ: begin
                busy    = 1'b1;
                dma_req = 1'b1;
                if (dma_ack)
                    state_n = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                dma_req = 1'b1;
                io_a    = idx[13:0];
                if (dma_ack)
                    state_n = S_COPY;
            end
            S_COPY: begin
                // io_a stays on idx so a stalled byte is re-read while ack is low.
                busy     = 1'b1;
                dma_req  = 1'b1;
                io_a     = idx[13:0];
                ram_addr = copy_addr;
                ram_dout = io_dout;
                if (dma_ack) begin
                    ram_we = 1'b1;
                    if (last_byte)
                        state_n = PATCH_PTRS ? S_PATCH : S_DONE;
                    else if (wrap)
                        state_n = S_DONE;
                    else
                        state_n = S_FETCH;
                end
            end
            S_PATCH: begin
                busy     = 1'b1;
                dma_req  = 1'b1;
                ram_addr = PTR_BASE + {13'd0, patch_cnt};
                ram_dout = patch_cnt[0] ? end_addr[15:8] : end_addr[7:0];
                if (dma_ack) begin
                    ram_we = 1'b1;
                    if (patch_cnt == 3'd5)
                        state_n = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_DONE;
            ram_we  = 1'b0;
            dma_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            dl_s1     <= 1'b0;
            dl_s2     <= 1'b0;
            dl_d      <= 1'b0;
            len       <= 16'd0;
            idx       <= 16'd0;
            load      <= 16'd0;
            hdr_cnt   <= 2'd0;
            patch_cnt <= 3'd0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            dl_s1 <= downloading;
            dl_s2 <= dl_s1;
            dl_d  <= dl_s2;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        len       <= size_len;
                        err       <= (size_len <= 16'd2);
                        idx       <= 16'd2;
                        hdr_cnt   <= 2'd0;
                        patch_cnt <= 3'd0;
                    end
                end
                S_HDR: begin
                    hdr_cnt <= hdr_cnt + 2'd1;
                    if (hdr_cnt == 2'd1)
                        load[7:0] <= io_dout;
                    if (hdr_cnt == 2'd2)
                        load[15:8] <= io_dout;
                end
                S_COPY: begin
                    if (dma_ack && !abort) begin
                        idx <= idx_inc;
                        if (wrap)
                            err <= 1'b1;
                    end
                end
                S_PATCH: begin
                    if (dma_ack && !abort)
                        patch_cnt <= patch_cnt + 3'd1;
                end
                default: ;
            endcase
            if (abort)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: buffer read model, RAM write monitor and
// per-scenario tasks comparing observed writes and status against hand-computed values.
module tb_prg_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        downloading;
    logic [15:0] size;
    logic [13:0] io_a;
    logic [7:0]  io_dout;
    logic        dma_req;
    logic        dma_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:16383];
    logic [23:0] wr_q [$];
    logic [23:0] exp_q [$];
    int          done_cnt;
    int          req_cnt;
    int          we_viol;

    prg_loader dut (
        .clk(clk), .reset_n(reset_n), .downloading(downloading), .size(size),
        .io_a(io_a), .io_dout(io_dout), .dma_req(dma_req), .dma_ack(dma_ack),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_we(ram_we), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // clock / buffer read port with one cycle of latency
    always #5 clk = ~clk;
    always @(posedge clk) io_dout <= mem[io_a];

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_we) wr_q.push_back({ram_addr, ram_dout});
        if (ram_we && !dma_ack) we_viol++;
        if (done) done_cnt++;
        if (dma_req) req_cnt++;
    end

    task automatic clear_log();
        wr_q.delete();
        exp_q.delete();
        done_cnt = 0;
        req_cnt  = 0;
        we_viol  = 0;
    endtask

    task automatic fill_basic();
        mem[0] = 8'h01; mem[1] = 8'h04; mem[2] = 8'hAA; mem[3] = 8'hBB; mem[4] = 8'hCC;
    endtask

    task automatic exp_basic();
        exp_q.push_back(24'h0401AA);
        exp_q.push_back(24'h0402BB);
        exp_q.push_back(24'h0403CC);
        for (int i = 0; i < 6; i++) exp_q.push_back({16'h002A + 16'(i), 8'h04});
    endtask

    task automatic start_load(input logic [15:0] sz);
        downloading = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        size = sz;
        downloading = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; downloading = 1'b0; size = 16'd0; dma_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (io_a !== 14'd0) begin errors++; $display("FAIL reset_io_a: got %h expected 0", io_a); end
        checks++; if (ram_addr !== 16'd0) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
        checks++; if (ram_dout !== 8'd0) begin errors++; $display("FAIL reset_ram_dout: got %h expected 0", ram_dout); end
        checks++; if ({ram_we, dma_req, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: we/req/busy/done/err got %b expected 00000", {ram_we, dma_req, busy, done, err});
        end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_copy();
        bit seen;
        clear_log(); fill_basic(); exp_basic();
        start_load(16'd5);
        wait_done(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_done_timeout: got no done expected done"); end
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_wr[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_header_only();
        bit seen;
        clear_log();
        start_load(16'd2);
        wait_done(50, seen);
        checks++; if (!seen) begin errors++; $display("FAIL short_done_timeout: got no done expected done"); end
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL short_dma_req: got %0d req cycles expected 0", req_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL short_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", err); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL short_writes: got %0d expected 0", wr_q.size()); end
    endtask

    task automatic test_wrap();
        bit seen;
        clear_log();
        mem[0] = 8'hFE; mem[1] = 8'hFF; mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h33; mem[5] = 8'h44;
        exp_q.push_back(24'hFFFE11);
        exp_q.push_back(24'hFFFF22);
        start_load(16'd6);
        wait_done(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL wrap_done_timeout: got no done expected done"); end
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_wr[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b expected 1", err); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_ack_stall();
        bit seen;
        bit hit;
        int n0;
        clear_log(); fill_basic(); exp_basic();
        start_load(16'd5);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (io_a == 14'd3) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL stall_reach_byte: got no fetch of idx 3 expected fetch"); end
        @(posedge clk);
        #1;
        dma_ack = 1'b0;
        n0 = wr_q.size();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_q.size() !== n0) begin errors++; $display("FAIL stall_writes_while_low: got %0d expected %0d", wr_q.size(), n0); end
        checks++; if (dma_req !== 1'b1) begin errors++; $display("FAIL stall_req_held: got %b expected 1", dma_req); end
        dma_ack = 1'b1;
        wait_done(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL stall_done_timeout: got no done expected done"); end
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_wr[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (we_viol !== 0) begin errors++; $display("FAIL stall_we_without_ack: got %0d expected 0", we_viol); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err: got %b expected 0", err); end
    endtask

    task automatic test_abort();
        bit seen;
        bit hit;
        bit fell;
        clear_log();
        mem[0] = 8'h00; mem[1] = 8'h10;
        for (int i = 0; i < 6; i++) mem[2 + i] = 8'(i + 1);
        exp_q.push_back(24'h100001);
        exp_q.push_back(24'h100102);
        start_load(16'd8);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (ram_we && ram_addr == 16'h1001) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_reach_2nd: got no 2nd write expected write"); end
        downloading = 1'b1;
        fell = 1'b0;
        for (int i = 0; i < 4 && !fell; i++) begin
            @(posedge clk);
            #1;
            if (!dma_req) fell = 1'b1;
        end
        checks++; if (!fell) begin errors++; $display("FAIL abort_req_fall: got dma_req=1 expected 0 within 4 clk"); end
        wait_done(20, seen);
        checks++; if (!seen) begin errors++; $display("FAIL abort_done_timeout: got no done expected done"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b expected 1", err); end
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_wr[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
        end
        // the re-raised download now finishes and starts a fresh load
        clear_log(); fill_basic(); exp_basic();
        size = 16'd5;
        downloading = 1'b0;
        wait_done(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL reload_done_timeout: got no done expected done"); end
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL reload_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL reload_wr[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reload_err: got %b expected 0", err); end
    endtask

    task automatic test_reset_in_patch();
        bit seen;
        bit hit;
        clear_log(); fill_basic();
        start_load(16'd5);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (ram_we && ram_addr == 16'h002C) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstp_reach_patch: got no patch write expected write"); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({ram_we, dma_req, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL rstp_flags: we/req/busy/done/err got %b expected 00000", {ram_we, dma_req, busy, done, err});
        end
        checks++; if (ram_addr !== 16'd0 || ram_dout !== 8'd0 || io_a !== 14'd0) begin
            errors++; $display("FAIL rstp_buses: addr %h dout %h io_a %h expected 0 0 0", ram_addr, ram_dout, io_a);
        end
        wr_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL rstp_no_partial: got %0d writes expected 0", wr_q.size()); end
        clear_log(); exp_basic();
        start_load(16'd5);
        wait_done(300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rstp_done_timeout: got no done expected done"); end
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstp_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstp_wr[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstp_err: got %b expected 0", err); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        clear_log();
        test_reset();
        test_basic_copy();
        test_header_only();
        test_wrap();
        test_ack_stall();
        test_abort();
        test_reset_in_patch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
